// File: rtl/perf_pkg.sv
// Shared types, constants and the saturating-add helper for the performance
// monitor family (monitor, history buffer, CSR front end).
package perf_pkg;

    localparam int PERF_COUNTER_WIDTH = 32;
    localparam int PERF_MAX_W         = 64;

    typedef logic [PERF_MAX_W-1:0] perf_wide_t;

    typedef struct packed {
        logic [PERF_COUNTER_WIDTH-1:0] total;
        logic [PERF_COUNTER_WIDTH-1:0] active;
        logic [PERF_COUNTER_WIDTH-1:0] idle;
    } perf_sample_t;

    // Callers truncate this to their own width, giving an all-ones minimum.
    localparam perf_wide_t PERF_MIN_INIT = '1;

    // Returns {overflow, result}: adds a and b, clamping to the all-ones
    // value of 'width' bits and flagging when the true sum did not fit.
    function automatic logic [PERF_MAX_W:0] perf_sat_add(
        input perf_wide_t  a,
        input perf_wide_t  b,
        input int unsigned width
    );
        logic [PERF_MAX_W:0] sum;
        perf_wide_t          lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (width >= PERF_MAX_W) ? '1
                                    : ((perf_wide_t'(1) << width) - perf_wide_t'(1));
        if (sum > {1'b0, lim}) begin
            return {1'b1, lim};
        end
        return sum;
    endfunction

endpackage

// File: rtl/perf_history_if.sv
// Index-addressed read port between the CSR block (master) and perf_history
// (slave): one request pulse in, one registered response pulse out.
interface perf_history_if #(
    parameter int COUNTER_WIDTH = 32,
    parameter int DEPTH         = 8
);
    localparam int AW = $clog2(DEPTH);

    logic                     rd_req;
    logic [AW-1:0]            rd_idx;
    logic                     rd_valid;
    logic                     rd_empty;
    logic [COUNTER_WIDTH-1:0] rd_total;
    logic [COUNTER_WIDTH-1:0] rd_active;
    logic [COUNTER_WIDTH-1:0] rd_idle;

    modport master (
        output rd_req, rd_idx,
        input  rd_valid, rd_empty, rd_total, rd_active, rd_idle
    );

    modport slave (
        input  rd_req, rd_idx,
        output rd_valid, rd_empty, rd_total, rd_active, rd_idle
    );

endinterface

// File: rtl/perf_history_ram.sv
// DEPTH x WIDTH register file: one synchronous write port and one registered
// read port whose output holds until the next read enable.
module perf_history_ram #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 96,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // NOTE: the storage array is deliberately left unreset; the fill count
    // upstream gates every read, and a reset would forbid RAM inference.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/perf_history.sv
// Circular history of the monitor's latched results plus running statistics,
// with a latency-1 read port addressed by age (0 = most recent run).
module perf_history
    import perf_pkg::*;
#(
    parameter int COUNTER_WIDTH = PERF_COUNTER_WIDTH,
    parameter int DEPTH         = 8,
    parameter int SUM_WIDTH     = 48
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       measurement_done,
    input  logic [COUNTER_WIDTH-1:0]   total_cycles_count,
    input  logic [COUNTER_WIDTH-1:0]   active_cycles_count,
    input  logic [COUNTER_WIDTH-1:0]   idle_cycles_count,
    input  logic                       clear,
    perf_history_if.slave              rd_bus,
    output logic [$clog2(DEPTH):0]     fill,
    output logic [COUNTER_WIDTH-1:0]   run_count,
    output logic [SUM_WIDTH-1:0]       sum_total,
    output logic [COUNTER_WIDTH-1:0]   min_total,
    output logic [COUNTER_WIDTH-1:0]   max_total,
    output logic                       sat_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = 3 * COUNTER_WIDTH;

    logic [AW-1:0]            r_wr_ptr;
    logic [AW:0]              r_fill;
    logic [COUNTER_WIDTH-1:0] r_run_count;
    logic [SUM_WIDTH-1:0]     r_sum;
    logic [COUNTER_WIDTH-1:0] r_min;
    logic [COUNTER_WIDTH-1:0] r_max;
    logic                     r_sat;
    logic                     r_rd_valid;
    logic                     r_rd_empty;

    logic                     w_capture;
    logic                     w_rd_hit;
    logic [AW-1:0]            w_rd_addr;
    logic [DW-1:0]            w_rdata;
    logic [PERF_MAX_W:0]      w_run_add;
    logic [PERF_MAX_W:0]      w_sum_add;
    logic                     w_unused_bits;

    assign w_capture = measurement_done & ~clear;

    // Age-to-slot mapping relies on AW-bit arithmetic wrapping modulo DEPTH.
    assign w_rd_addr = r_wr_ptr - AW'(1) - rd_bus.rd_idx;
    assign w_rd_hit  = {1'b0, rd_bus.rd_idx} < r_fill;

    assign w_run_add = perf_sat_add(perf_wide_t'(r_run_count), perf_wide_t'(1),
                                    COUNTER_WIDTH);
    assign w_sum_add = perf_sat_add(perf_wide_t'(r_sum), perf_wide_t'(total_cycles_count),
                                    SUM_WIDTH);
    assign w_unused_bits = ^{w_run_add[PERF_MAX_W-1:COUNTER_WIDTH],
                             w_sum_add[PERF_MAX_W-1:SUM_WIDTH]};

    perf_history_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_capture),
        .i_waddr (r_wr_ptr),
        .i_wdata ({total_cycles_count, active_cycles_count, idle_cycles_count}),
        .i_re    (rd_bus.rd_req & w_rd_hit),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    // Clear beats a coincident capture: the sample is dropped entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_run_count <= '0;
            r_sum       <= '0;
            r_min       <= COUNTER_WIDTH'(PERF_MIN_INIT);
            r_max       <= '0;
            r_sat       <= 1'b0;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_run_count <= '0;
            r_sum       <= '0;
            r_min       <= COUNTER_WIDTH'(PERF_MIN_INIT);
            r_max       <= '0;
            r_sat       <= 1'b0;
        end else if (measurement_done) begin
            r_wr_ptr    <= r_wr_ptr + AW'(1);
            if (r_fill != (AW+1)'(DEPTH)) begin
                r_fill <= r_fill + (AW+1)'(1);
            end
            r_run_count <= w_run_add[COUNTER_WIDTH-1:0];
            r_sum       <= w_sum_add[SUM_WIDTH-1:0];
            if (total_cycles_count < r_min) begin
                r_min <= total_cycles_count;
            end
            if (total_cycles_count > r_max) begin
                r_max <= total_cycles_count;
            end
            r_sat <= r_sat | w_run_add[PERF_MAX_W] | w_sum_add[PERF_MAX_W];
        end
    end

    // Read control ignores clear so an in-flight read returns pre-clear data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_empty <= 1'b0;
        end else begin
            r_rd_valid <= rd_bus.rd_req;
            if (rd_bus.rd_req) begin
                r_rd_empty <= ~w_rd_hit;
            end
        end
    end

    assign rd_bus.rd_valid  = r_rd_valid;
    assign rd_bus.rd_empty  = r_rd_empty;
    assign rd_bus.rd_total  = r_rd_empty ? '0 : w_rdata[DW-1 -: COUNTER_WIDTH];
    assign rd_bus.rd_active = r_rd_empty ? '0 : w_rdata[2*COUNTER_WIDTH-1 -: COUNTER_WIDTH];
    assign rd_bus.rd_idle   = r_rd_empty ? '0 : w_rdata[COUNTER_WIDTH-1:0];

    assign fill      = r_fill;
    assign run_count = r_run_count;
    assign sum_total = r_sum;
    assign min_total = (r_run_count == '0) ? '0 : r_min;
    assign max_total = r_max;
    assign sat_flag  = r_sat;

endmodule
